// File: rtl/gearbox_20to16.sv
// 20-bit to 16-bit width converter over a 32-nibble circular buffer.
// Nibble order is preserved; data_in[3:0] and data_out[3:0] are oldest.
module gearbox_20to16 (
  input  logic        clk,
  input  logic        res,
  input  logic        shift_in,
  input  logic [19:0] data_in,
  input  logic        shift_out,
  output logic        full,
  output logic [5:0]  fill,
  output logic        valid_out,
  output logic [15:0] data_out
);

  logic [3:0]  mem_q [32];
  logic [4:0]  wr_ptr_q, wr_ptr_d;
  logic [4:0]  rd_ptr_q, rd_ptr_d;
  logic [5:0]  fill_q, fill_d;
  logic        valid_q, valid_d;
  logic [15:0] dout_q, dout_d;
  logic        wr_acc, rd_acc;

  assign full   = fill_q > 6'd27;
  assign wr_acc = shift_in & ~full;
  assign rd_acc = shift_out & (fill_q >= 6'd4);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    valid_d  = rd_acc;
    dout_d   = dout_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 5'd5;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 5'd4;
      for (int k = 0; k < 4; k++) begin
        dout_d[4*k +: 4] = mem_q[rd_ptr_q + 5'(k)];
      end
    end
    // Gating keeps this within 0..32, so 6 bits never wrap.
    fill_d = fill_q
           + (wr_acc ? 6'd5 : 6'd0)
           - (rd_acc ? 6'd4 : 6'd0);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is not reset; fill gating hides stale entries.
  always_ff @(posedge clk) begin
    if (!res && wr_acc) begin
      for (int k = 0; k < 5; k++) begin
        mem_q[wr_ptr_q + 5'(k)] <= data_in[4*k +: 4];
      end
    end
  end

  assign fill      = fill_q;
  assign valid_out = valid_q;
  assign data_out  = dout_q;

endmodule

// File: tb/tb_gearbox_20to16.sv
// Scoreboard bench for gearbox_20to16.
// Expected words are queued at issue; a monitor pops on valid_out.
module tb_gearbox_20to16;

  logic        clk = 1'b0;
  logic        res;
  logic        shift_in;
  logic [19:0] data_in;
  logic        shift_out;
  logic        full;
  logic [5:0]  fill;
  logic        valid_out;
  logic [15:0] data_out;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  gearbox_20to16 dut (
    .clk       (clk),
    .res       (res),
    .shift_in  (shift_in),
    .data_in   (data_in),
    .shift_out (shift_out),
    .full      (full),
    .fill      (fill),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every presented word against the queue head.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got %h expected none", data_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL data_out: got %h expected %h", data_out, e);
        end
      end
    end
  end

  task automatic step(input logic si, input logic [19:0] d,
                      input logic so, input logic r);
    shift_in  = si;
    data_in   = d;
    shift_out = so;
    res       = r;
    @(posedge clk);
    #1;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    res       = 1'b0;
  endtask

  task automatic wr(input logic [19:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [15:0] e);
    exp_q.push_back(e);
    step(1'b0, 20'h0, 1'b1, 1'b0);
  endtask

  task automatic rst();
    step(1'b0, 20'h0, 1'b0, 1'b1);
  endtask

  task automatic fill30();
    wr(20'h43210);
    wr(20'h98765);
    wr(20'hEDCBA);
    wr(20'h3210F);
    wr(20'h87654);
    wr(20'hDCBA9);
  endtask

  function automatic logic [19:0] wword(input logic [3:0] n);
    logic [19:0] w;
    for (int k = 0; k < 5; k++) w[4*k +: 4] = n + 4'(k);
    return w;
  endfunction

  function automatic logic [15:0] rword(input logic [3:0] n);
    logic [15:0] w;
    for (int k = 0; k < 4; k++) w[4*k +: 4] = n + 4'(k);
    return w;
  endfunction

  initial begin
    res = 1'b1; shift_in = 1'b0; shift_out = 1'b0; data_in = '0;
    @(posedge clk); #1;
    rst();
    chk("rst_fill", fill, 0);
    chk("rst_full", full, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_dout", data_out, 0);

    // Reads on empty buffer are rejected.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 20'h0, 1'b1, 1'b0);
      chk("empty_valid", valid_out, 0);
      chk("empty_dout", data_out, 0);
      chk("empty_fill", fill, 0);
    end

    // Basic stream.
    wr(20'h43210);
    chk("w1_fill", fill, 5);
    wr(20'h98765);
    wr(20'hEDCBA);
    wr(20'h3210F);
    chk("w4_fill", fill, 20);
    rd(16'h3210);
    chk("r1_valid", valid_out, 1);
    rd(16'h7654);
    rd(16'hBA98);
    rd(16'hFEDC);
    rd(16'h3210);
    chk("stream_fill", fill, 0);
    step(1'b0, 20'h0, 1'b0, 1'b0);
    chk("hold_valid", valid_out, 0);
    chk("hold_dout", data_out, 16'h3210);

    // Full boundary.
    fill30();
    chk("full_fill", fill, 30);
    chk("full_flag", full, 1);
    wr(20'hFFFFF);
    chk("drop_fill", fill, 30);
    rd(16'h3210);
    chk("unfull_fill", fill, 26);
    chk("unfull_flag", full, 0);
    rd(16'h7654);
    rd(16'hBA98);
    rd(16'hFEDC);
    rd(16'h3210);
    rd(16'h7654);
    rd(16'hBA98);
    chk("drain_fill", fill, 2);
    step(1'b0, 20'h0, 1'b1, 1'b0);
    chk("short_valid", valid_out, 0);
    chk("short_dout", data_out, 16'hBA98);
    rst();

    // Simultaneous write and read at fill 8.
    wr(20'h43210);
    wr(20'h98765);
    wr(20'hEDCBA);
    wr(20'h3210F);
    rd(16'h3210);
    rd(16'h7654);
    rd(16'hBA98);
    chk("sim_pre_fill", fill, 8);
    exp_q.push_back(16'hFEDC);
    step(1'b1, 20'h87654, 1'b1, 1'b0);
    chk("sim_fill", fill, 9);
    chk("sim_valid", valid_out, 1);
    chk("sim_dout", data_out, 16'hFEDC);
    rd(16'h3210);
    rd(16'h7654);
    chk("sim_left", fill, 1);
    rst();

    // Reset mid-operation dominates shift_in/shift_out.
    fill30();
    chk("mid_pre_fill", fill, 30);
    step(1'b1, 20'h11111, 1'b1, 1'b1);
    chk("mid_fill", fill, 0);
    chk("mid_full", full, 0);
    chk("mid_valid", valid_out, 0);
    chk("mid_dout", data_out, 0);
    wr(20'hABCDE);
    rd(16'hBCDE);
    chk("mid_new_fill", fill, 1);
    rst();

    // Wrap-around: 4 writes per 5 cycles, read whenever allowed.
    begin
      logic [3:0] wn, rn;
      int mf;
      logic si;
      wn = 4'h0;
      rn = 4'h0;
      mf = 0;
      for (int c = 0; c < 200; c++) begin
        si = (c % 5) != 4;
        if (mf >= 4) begin
          exp_q.push_back(rword(rn));
          rn = rn + 4'd4;
        end
        step(si, wword(wn), 1'b1, 1'b0);
        mf = mf + ((si && mf <= 27) ? 5 : 0) - ((mf >= 4) ? 4 : 0);
        if (si) wn = wn + 4'd5;
        if (fill > 6'd32) begin
          chk("wrap_bound", fill, 32);
        end
        if (c % 10 == 0) chk("wrap_fill", fill, mf);
      end
      for (int c = 0; c < 20 && mf >= 4; c++) begin
        exp_q.push_back(rword(rn));
        rn = rn + 4'd4;
        step(1'b0, 20'h0, 1'b1, 1'b0);
        mf = mf - 4;
      end
      chk("wrap_end_fill", fill, mf);
    end

    step(1'b0, 20'h0, 1'b0, 1'b0);
    step(1'b0, 20'h0, 1'b0, 1'b0);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gearbox_20to16.md
# gearbox_20to16

Width converter from a 20-bit to a 16-bit word stream. It is the transmit-side counterpart of the 16-to-20 gearbox. A producer pushes 20-bit words and a consumer pulls 16-bit words. Data passes through a 32-nibble circular buffer, so the nibble stream order is preserved exactly across the width change.

## Interface
- Parameters: none. The buffer is fixed at 32 × 4-bit entries, with 5-bit pointers.
- clk  input  1  Sole clock. All state updates on the rising edge.
- res  input  1  Reset. Synchronous, active-high.
- shift_in  input  1  Write request for data_in this cycle.
- data_in  input  20  Input word. data_in[3:0] is the oldest nibble.
- shift_out  input  1  Read request for one 16-bit word.
- full  output  1  Combinational. High when fill > 27, i.e. fewer than 5 free nibbles.
- fill  output  6  Registered count of occupied nibbles, range 0..32.
- valid_out  output  1  Registered. One-cycle pulse marking a new data_out.
- data_out  output  16  Registered output word. data_out[3:0] is the oldest nibble.

## Operation
- State:
  - wr_ptr[4:0], rd_ptr[4:0], fill[5:0].
  - buf[0:31] of 4-bit entries. Buffer contents are not reset.
- Write accept: wr_acc = shift_in & ~full.
  - buf[wr_ptr+k] <= data_in[4k+3:4k] for k = 0..4.
  - wr_ptr += 5.
- Read accept: rd_acc = shift_out & (fill >= 4).
  - data_out[4k+3:4k] <= buf[rd_ptr+k] for k = 0..3.
  - rd_ptr += 4.
  - valid_out <= 1. Otherwise valid_out <= 0.
- Pointer arithmetic is 5-bit modulo 32. Wrap-around is natural, with no special casing.
- fill_next = fill + 5·wr_acc − 4·rd_acc, computed in 6 bits. It can never overflow or underflow under these gating rules.
- Both accept conditions use the current-cycle fill. A simultaneous write and read are both honoured.
- A rejected write (full) is dropped silently: no pointer or buffer change. The producer must hold or retry.
- A rejected read (fill < 4) gives valid_out = 0 the next cycle. data_out holds its previous value.
- data_out holds its value whenever no read is accepted.
- Reset (res = 1 at a clock edge) sets:
  - wr_ptr = 0, rd_ptr = 0, fill = 0.
  - valid_out = 0, data_out = 16'h0000, hence full = 0.
- Reset takes priority over any same-cycle shift_in or shift_out, including mid-stream. Any data in flight is discarded.

## Timing
- A write accepted at edge N is visible in fill after edge N. It is readable by a request sampled at edge N+1.
- Read latency is 1 cycle. With shift_out high and fill ≥ 4 before edge N, data_out and valid_out are updated at edge N.
- A read in the same cycle as a write sees the pre-write buffer. There is no bypass; fill gating guarantees the read nibbles are already written.
- full is derived combinationally from registered fill and is valid throughout the cycle.
- Sustained throughput is 4 writes per 5 reads. Continuous shift_in and shift_out with this ratio must never stall once fill ≥ 4.

## Test plan
- Reset, then shift_out = 1 for 3 cycles with empty buffer. Required: valid_out stays 0, data_out = 16'h0000, fill = 0.
- Write 20'h43210, 20'h98765, 20'hEDCBA, 20'h3210F, then 5 reads. Required, in order: data_out 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'h3210. Each comes with a valid_out pulse; fill returns to 0.
- Full boundary: 6 writes with no reads give fill 30 and full = 1. A 7th write is ignored (fill stays 30). One read gives fill 26 and full = 0.
- Simultaneous: with fill = 8, assert shift_in and shift_out in one cycle. Required: fill = 9, valid_out = 1, and the oldest 4 nibbles are output.
- Wrap-around: stream an incrementing nibble pattern for 200 cycles, writing 4 of every 5 cycles and reading every cycle when allowed. Required: the output nibble sequence is contiguous and incrementing, and fill stays ≤ 32.
- Reset mid-operation: at fill = 30 with shift_in and shift_out high, pulse res for 1 cycle. Required after the edge: fill = 0, full = 0, valid_out = 0, data_out = 16'h0000. The next write and read returns the new data only.
